// File: rtl/shift_arb_pkg.sv
// Purpose: shared types and shift-type encodings for the shift unit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: SHIFT_* type codes, shift_op_t operand bundle.
package shift_arb_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_ROL = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] shamt;
    logic [1:0] shift_type;
  } shift_op_t;

endpackage

// File: rtl/barrel_shifter_8bit.sv
// Purpose: combinational 8-bit shifter/rotator (SLL/SRL zero-fill, ROL/ROR).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: data/shamt/shift_type operands in, result out.
module barrel_shifter_8bit
  import shift_arb_pkg::*;
(
  input  logic [7:0] data,
  input  logic [2:0] shamt,
  input  logic [1:0] shift_type,
  output logic [7:0] result
);

  logic [3:0] inv_amt;

  // Complementary amount for rotates; at shamt=0 this is 8, which shifts an
  // 8-bit value out entirely, so the rotate collapses to the plain operand.
  assign inv_amt = 4'd8 - {1'b0, shamt};

  always_comb begin
    result = data;
    case (shift_type)
      SHIFT_SLL: result = data << shamt;
      SHIFT_SRL: result = data >> shamt;
      SHIFT_ROL: result = (data << shamt) | (data >> inv_amt);
      SHIFT_ROR: result = (data >> shamt) | (data << inv_amt);
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/shift_rr_arbiter.sv
// Purpose: round-robin priority picker, search starts at rr_ptr and wraps.
// Latency: 0 cycles, purely combinational.
// Backpressure: enable=0 forces an empty grant.
// Ports: req, rr_ptr, enable in; one-hot gnt, binary gnt_idx, gnt_vld out.
module shift_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_vld
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int cand;
      // rr_ptr is always below NUM_REQ, so one conditional wrap suffices.
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (enable && !gnt_vld && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = ID_W'(cand);
        gnt_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Purpose: shares one 8-bit barrel shifter between NUM_REQ requesters, round-robin.
// Latency: 1 cycle from request accept to resp_valid; one result per cycle sustained.
// Backpressure: resp stall (resp_valid & !resp_ready) holds resp_* and drops all req_ready.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_data/req_shamt/req_type per
//   requester; resp_valid/resp_ready/resp_data/resp_id result port.
// Option: define SHIFT_ARB_STATS_EN to add grant_count (16-bit saturating per requester).
module shift_unit_arbiter
  import shift_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [3*NUM_REQ-1:0] req_shamt,
  input  logic [2*NUM_REQ-1:0] req_type,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_data,
  output logic [ID_W-1:0]      resp_id
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0] grant_count
`endif
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    rr_ptr;
  logic               can_accept;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_vld;
  shift_op_t          ops [NUM_REQ];
  shift_op_t          sel_op;
  logic [7:0]         shift_result;

  // The output register frees up in the same cycle it is drained.
  assign can_accept = !resp_valid || resp_ready;

  shift_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .enable (can_accept && !rst),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld)
  );

  assign req_ready = gnt;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ops
    assign ops[gi] = {req_data[8*gi +: 8], req_shamt[3*gi +: 3], req_type[2*gi +: 2]};
  end

  assign sel_op = ops[gnt_idx];

  barrel_shifter_8bit u_shift (
    .data      (sel_op.data),
    .shamt     (sel_op.shamt),
    .shift_type(sel_op.shift_type),
    .result    (shift_result)
  );

  // gnt_vld already implies req_valid & req_ready, i.e. a transfer this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      rr_ptr     <= '0;
    end else if (gnt_vld) begin
      resp_valid <= 1'b1;
      resp_data  <= shift_result;
      resp_id    <= gnt_idx;
      rr_ptr     <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  for (genvar ci = 0; ci < NUM_REQ; ci++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (gnt[ci] && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign grant_count[16*ci +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Purpose: self-checking bench for shift_unit_arbiter: directed cases plus randomized traffic.
// Latency: results expected one cycle after each accept.
// Backpressure: random resp_ready; requesters hold operands stable until accepted.
module tb_shift_unit_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_data;
  logic [3*N-1:0] req_shamt;
  logic [2*N-1:0] req_type;
  logic           resp_valid;
  logic           resp_ready;
  logic [7:0]     resp_data;
  logic [IW-1:0]  resp_id;
`ifdef SHIFT_ARB_STATS_EN
  logic [16*N-1:0] grant_count;
`endif

  always #5 clk = ~clk;

  shift_unit_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shamt  (req_shamt),
    .req_type   (req_type),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift one bit position at a time, amt times.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input int typ);
    logic [7:0] x;
    x = d;
    for (int s = 0; s < amt; s++) begin
      case (typ)
        0:       x = {x[6:0], 1'b0};
        1:       x = {1'b0, x[7:1]};
        2:       x = {x[6:0], x[7]};
        default: x = {x[0], x[7:1]};
      endcase
    end
    return x;
  endfunction

  logic [7:0] op_d [N];
  logic [2:0] op_s [N];
  logic [1:0] op_t [N];

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8]  = op_d[i];
      req_shamt[3*i +: 3] = op_s[i];
      req_type[2*i +: 2]  = op_t[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: output register contents, priority pointer, fairness waits.
  bit         chk_en = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_id = 0;
  int         m_ptr = 0;
  int         wait_cnt [N];
`ifdef SHIFT_ARB_STATS_EN
  int         m_cnt [N];
`endif

  always @(negedge clk) begin
    int         g;
    logic [N-1:0] exp_rdy;
    g = -1;
    exp_rdy = '0;
    if (!rst && (!m_valid || resp_ready)) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("resp_valid", 32'(resp_valid), 32'(m_valid));
      check("resp_data", 32'(resp_data), 32'(m_data));
      check("resp_id", 32'(resp_id), 32'(m_id));
      if (g >= 0) check("fairness_wait_ok", 32'(wait_cnt[g] <= N - 1), 32'd1);
    end
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_id    = 0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
`ifdef SHIFT_ARB_STATS_EN
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    end else begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = ref_shift(req_data[8*g +: 8], int'(req_shamt[3*g +: 3]), int'(req_type[2*g +: 2]));
        m_id    = g;
        m_ptr   = (g + 1) % N;
`ifdef SHIFT_ARB_STATS_EN
        if (m_cnt[g] < 65535) m_cnt[g] = m_cnt[g] + 1;
`endif
        for (int i = 0; i < N; i++) begin
          if (i == g || !req_valid[i]) wait_cnt[i] = 0;
          else wait_cnt[i] = wait_cnt[i] + 1;
        end
      end else begin
        if (resp_ready) m_valid = 1'b0;
        for (int i = 0; i < N; i++) if (!req_valid[i]) wait_cnt[i] = 0;
      end
    end
  end

  logic [7:0] lit_b3 [4];
  logic [N-1:0] acc;

  initial begin
    lit_b3[0] = 8'hCC;
    lit_b3[1] = 8'h2C;
    lit_b3[2] = 8'hCE;
    lit_b3[3] = 8'hEC;
    for (int i = 0; i < N; i++) begin
      op_d[i] = 8'h00;
      op_s[i] = 3'd0;
      op_t[i] = 2'd0;
      wait_cnt[i] = 0;
`ifdef SHIFT_ARB_STATS_EN
      m_cnt[i] = 0;
`endif
    end
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    drive_bus();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", 32'(resp_data), 32'd0);
    check("reset_resp_id", 32'(resp_id), 32'd0);

    // Directed: B3 shifted by 2 for each type, and shamt=0 passthrough of 5A.
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      check("model_b3", 32'(ref_shift(8'hB3, 2, t)), 32'(lit_b3[t]));
      op_d[0] = 8'hB3; op_s[0] = 3'd2; op_t[0] = 2'(t);
      req_valid = 4'b0001;
      drive_bus();
      step();
      req_valid = '0;
      #3;
      check("b3_valid", 32'(resp_valid), 32'd1);
      check("b3_data", 32'(resp_data), 32'(lit_b3[t]));
      check("b3_id", 32'(resp_id), 32'd0);
    end
    for (int t = 0; t < 4; t++) begin
      op_d[0] = 8'h5A; op_s[0] = 3'd0; op_t[0] = 2'(t);
      req_valid = 4'b0001;
      drive_bus();
      step();
      req_valid = '0;
      #3;
      check("shamt0_data", 32'(resp_data), 32'h5A);
    end

    // All requesters valid: strict rotation 0,1,2,3 with back-to-back results.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_d[i] = 8'(8'h13 + 8'h22 * i); op_s[i] = 3'(i + 1); op_t[i] = 2'(i);
    end
    drive_bus();
    req_valid = '1;
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #3;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % N)));
      step();
      check("rr_resp_valid", 32'(resp_valid), 32'd1);
      check("rr_resp_id", 32'(resp_id), 32'(k % N));
    end

    // Output stall for 3 cycles, then release resumes at requester 0.
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      check("stall_ready", 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    #3;
    check("release_ready", 32'(req_ready), 32'b0001);
    step();

    // Reset with a pending result and live requests.
    resp_ready = 1'b0;
    rst = 1'b1;
    #3;
    check("rst_ready", 32'(req_ready), 32'd0);
    step();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #3;
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    step();

    // Randomized traffic with random backpressure and occasional reset.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      rst = ($urandom_range(0, 199) == 0);
      resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          op_d[i] = 8'($urandom);
          op_s[i] = 3'($urandom_range(0, 7));
          op_t[i] = 2'($urandom_range(0, 3));
        end
      end
      drive_bus();
    end

`ifdef SHIFT_ARB_STATS_EN
    @(negedge clk);
    for (int i = 0; i < N; i++) check("stats_random", 32'(grant_count[16*i +: 16]), 32'(m_cnt[i]));
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    repeat (10) step();
    req_valid = '0;
    step();
    check("stats_req2", 32'(grant_count[47:32]), 32'd10);
    check("stats_req0", 32'(grant_count[15:0]), 32'd0);
    check("stats_req1", 32'(grant_count[31:16]), 32'd0);
    check("stats_req3", 32'(grant_count[63:48]), 32'd0);
`endif

    req_valid = '0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
